// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW front end.
package vliw_pkg;

    localparam int unsigned BUNDLE_W  = 128;
    localparam int unsigned SLOT_W    = 32;
    localparam int unsigned NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    localparam logic [BUNDLE_W-1:0] HALT_BUNDLE = '0;

    typedef struct packed {
        logic [31:0]         pc;
        logic [BUNDLE_W-1:0] bundle;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched bundles; head is read straight from storage.
module fetch_queue
    import vliw_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_pop;
    logic            do_push;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, memory issue/capture, redirect and halt handling.
module fetch_unit
    import vliw_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] PC_STEP    = 32'd16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [31:0]         mem_pc,
    input  logic [BUNDLE_W-1:0] mem_bundle,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                bundle_valid,
    input  logic                bundle_ready,
    output logic [BUNDLE_W-1:0] bundle,
    output logic [31:0]         bundle_pc,
    output logic                halted
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          redirect_en;
    logic          issue;
    logic          capture;
    logic          halt_hit;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  din;
    logic          unused_lsb;

    assign unused_lsb = ^redirect_pc[3:0];

    // Space check counts the outstanding response but gives no credit for a same-cycle pop.
    assign used = {1'b0, count} + {{CW{1'b0}}, inflight};

    always_comb begin
        state_d     = state_q;
        redirect_en = redirect_valid && (state_q != IDLE);
        issue       = (state_q == RUN) && !redirect_valid && (used < DEPTH_L);
        capture     = inflight && (state_q == RUN) && !redirect_valid;
        halt_hit    = capture && (mem_bundle == HALT_BUNDLE);
        push        = capture && (mem_bundle != HALT_BUNDLE);
        pop         = bundle_valid && bundle_ready;
        din.pc      = inflight_pc;
        din.bundle  = mem_bundle;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!redirect_valid && halt_hit) state_d = HALTED;
            HALTED:  if (redirect_valid) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state_q  <= state_d;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (redirect_en) begin
                pc <= {redirect_pc[31:4], 4'b0};
            end else if (issue && !halt_hit) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    fetch_queue #(.DEPTH(FIFO_DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_en),
        .din   (din),
        .count (count),
        .head  (head)
    );

    assign mem_pc       = pc;
    assign bundle_valid = (count != '0);
    assign bundle       = head.bundle;
    assign bundle_pc    = head.pc;
    assign halted       = (state_q == HALTED);

endmodule
